handshake_fifo_break_dv: RTL and testbench



---
 rtl/handshake_fifo_break_dv.sv | 103 ++++++++++
 tb/tb_handshake_fifo_break_dv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_break_dv.sv
// handshake_fifo_break_dv
// Elastic NUM_SLOTS-deep FIFO on a valid/ready channel. It breaks both the
// valid path and the ready path: outs/outs_valid come from registered state,
// and ins_ready depends only on the registered occupancy (and rst), never on
// outs_ready. A token accepted in cycle t is offered downstream from t+1.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset (flushes all held tokens)
//   ins         incoming token data
//   ins_valid   upstream offers a token
//   ins_ready   FIFO can accept a token this cycle
//   outs        data of the oldest stored token (don't care when !outs_valid)
//   outs_valid  FIFO holds at least one token
//   outs_ready  downstream accepts the offered token
module handshake_fifo_break_dv #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);

  // Pointers wrap explicitly at the last slot so odd depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [NUM_SLOTS];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      count_next_s;

  // Flags and handshakes derived only from registered occupancy.
  always_comb begin
    full_s     = (count_r == FULL_COUNT);
    empty_s    = (count_r == {CNT_W{1'b0}});
    ins_ready  = !full_s && !rst;
    outs_valid = !empty_s;
    outs       = mem_r[rd_ptr_r];
    push_s     = ins_valid && ins_ready;
    pop_s      = outs_valid && outs_ready;
  end

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Control state: pointers and count, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_next_s;
    end
  end

  // Storage write; data is not reset (push is already blocked during rst).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ins;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
module tb_handshake_fifo_break_dv;

  logic        clk = 1'b0;
  logic        rst;
  logic        started = 1'b0;

  logic [31:0] ins4, outs4;
  logic        ins_valid4, ins_ready4, outs_valid4, outs_ready4;
  logic [31:0] ins3, outs3;
  logic        ins_valid3, ins_ready3, outs_valid3, outs_ready3;

  int checks = 0;
  int passes = 0;

  logic [31:0] q4[$];
  logic [31:0] q3[$];
  logic [31:0] log4[$];
  int          cnt4 = 0;
  int          cnt3 = 0;
  int          pops3 = 0;

  always #5 clk = ~clk;

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
    .clk(clk), .rst(rst),
    .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4)
  );

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard/monitor for the 4-slot instance, sampled mid-cycle.
  initial begin
    logic er, ev, push, pop;
    forever begin
      @(negedge clk);
      if (started) begin
        er = (cnt4 < 4) && !rst;
        ev = (cnt4 > 0);
        chk("ins_ready4", {31'd0, ins_ready4}, {31'd0, er});
        chk("outs_valid4", {31'd0, outs_valid4}, {31'd0, ev});
        if (ev && q4.size() > 0) chk("outs4", outs4, q4[0]);
        if (rst) begin
          q4.delete();
          cnt4 = 0;
        end else begin
          pop  = ev && outs_ready4;
          push = ins_valid4 && er;
          if (pop) log4.push_back(q4.pop_front());
          if (push) q4.push_back(ins4);
          cnt4 = cnt4 + (push ? 1 : 0) - (pop ? 1 : 0);
        end
      end
    end
  end

  // Scoreboard/monitor for the 3-slot instance.
  initial begin
    logic er, ev, push, pop;
    forever begin
      @(negedge clk);
      if (started) begin
        er = (cnt3 < 3) && !rst;
        ev = (cnt3 > 0);
        if (ins_ready3 !== er) chk("ins_ready3", {31'd0, ins_ready3}, {31'd0, er});
        if (outs_valid3 !== ev) chk("outs_valid3", {31'd0, outs_valid3}, {31'd0, ev});
        if (ev && q3.size() > 0) chk("outs3", outs3, q3[0]);
        if (rst) begin
          q3.delete();
          cnt3 = 0;
        end else begin
          pop  = ev && outs_ready3;
          push = ins_valid3 && er;
          if (pop) begin
            void'(q3.pop_front());
            pops3++;
          end
          if (push) q3.push_back(ins3);
          cnt3 = cnt3 + (push ? 1 : 0) - (pop ? 1 : 0);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    ins_valid4  = v;
    ins4        = d;
    outs_ready4 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input logic [31:0] exp[$]);
    logic ok;
    ok = (log4.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++) if (log4[i] !== exp[i]) ok = 1'b0;
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int sent, budget;
    logic acc;

    rst = 1'b1;
    ins_valid4 = 1'b0; ins4 = 32'd0; outs_ready4 = 1'b0;
    ins_valid3 = 1'b0; ins3 = 32'd0; outs_ready3 = 1'b0;
    @(posedge clk);
    #1 started = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill 4 slots, then offer a fifth token while full and blocked.
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    cyc(1'b1, 32'h44, 1'b0);
    cyc(1'b1, 32'h55, 1'b0);
    // Drain from full.
    log4.delete();
    repeat (5) cyc(1'b0, 32'h0, 1'b1);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    chk_log("drain_order", exp_q);

    // Full plus pop: no push on the full cycle, accepted the next.
    log4.delete();
    cyc(1'b1, 32'h1, 1'b0);
    cyc(1'b1, 32'h2, 1'b0);
    cyc(1'b1, 32'h3, 1'b0);
    cyc(1'b1, 32'h4, 1'b0);
    cyc(1'b1, 32'h5, 1'b1);
    cyc(1'b1, 32'h5, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    chk_log("full_plus_pop", exp_q);

    // Streaming 0..99 at one token per cycle.
    log4.delete();
    for (int i = 0; i < 100; i++) cyc(1'b1, i, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(i);
    chk_log("stream_order", exp_q);

    // Reset mid-operation with two tokens held and ins_valid high.
    cyc(1'b1, 32'hA1, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 32'hBB, 1'b0);
    rst = 1'b0;
    log4.delete();
    cyc(1'b1, 32'hAA, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    exp_q = '{32'hAA};
    chk_log("reset_flush", exp_q);

    // Odd depth, random valid/ready, 500 tokens.
    sent = 0;
    budget = 0;
    pops3 = 0;
    while (sent < 500 && budget < 20000) begin
      ins_valid3  = ($urandom_range(0, 9) < 7);
      ins3        = sent;
      outs_ready3 = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = ins_valid3 && ins_ready3;
      @(posedge clk);
      #1;
      if (acc) sent++;
      budget++;
    end
    chk("rand_sent_budget", sent, 32'd500);
    ins_valid3  = 1'b0;
    outs_ready3 = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("rand_pops", pops3, 32'd500);
    chk("rand_queue_empty", q3.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
